// File: rtl/sdp_ram_pipe_if.sv
// sdp_ram_pipe_if: write/read request bus for sdp_ram_pipe.
// master drives write and read requests; slave returns read data,
// the read-valid strobe and the clear-busy flag.
interface sdp_ram_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic [NB-1:0]         wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  doutb_valid;
  logic                  init_busy;

  modport master (
    output wea, addra, dina, enb, addrb,
    input  doutb, doutb_valid, init_busy
  );

  modport slave (
    input  wea, addra, dina, enb, addrb,
    output doutb, doutb_valid, init_busy
  );
endinterface

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: single-clock simple-dual-port RAM with per-byte write
// enables, a READ_LATENCY-deep read pipeline with valid strobe, and a
// post-reset clear pass that writes INIT_DATA to every entry.
// Optional macro SDP_RAM_BYPASS_EN forwards same-cycle write bytes to a
// colliding read; without it collisions are read-first.
module sdp_ram_pipe #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 9,
  parameter int                    RAM_DEPTH    = 512,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA    = '0
) (
  input logic          clka,
  input logic          rst,
  sdp_ram_pipe_if.slave bus
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  run;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  tail_valid;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;

  assign run     = (state_q == S_RUN);
  assign wr_ok   = ({1'b0, bus.addra} < DEPTH_W);
  assign rd_ok   = ({1'b0, bus.addrb} < DEPTH_W);
  assign rd_fire = run & bus.enb;

  // FSM state and clear counter
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every entry once, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Memory array: clear writes during S_INIT, byte-masked writes in S_RUN
  always_ff @(posedge clka) begin
    if (state_q == S_INIT) begin
      mem[cnt_q] <= INIT_DATA;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wea[i]) begin
          mem[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read word: stored data (pre-write), zero when out of range
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.addrb];
`ifdef SDP_RAM_BYPASS_EN
      if ((|bus.wea) && (bus.addra == bus.addrb)) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (bus.wea[i]) begin
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
`endif
    end
  end

  // The output register is the final pipeline stage, so only
  // READ_LATENCY-1 intermediate stages are needed.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign tail_valid = rd_fire;
      assign tail_data  = rd_word;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] sh_valid;
      logic [DATA_WIDTH-1:0]   sh_data [READ_LATENCY-1];

      // Intermediate read stages shift one step per cycle
      always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
          sh_valid <= '0;
          sh_data  <= '{default: '0};
        end else begin
          sh_valid[0] <= rd_fire;
          sh_data[0]  <= rd_word;
          for (int unsigned i = 1; i < READ_LATENCY - 1; i++) begin
            sh_valid[i] <= sh_valid[i-1];
            sh_data[i]  <= sh_data[i-1];
          end
        end
      end

      assign tail_valid = sh_valid[READ_LATENCY-2];
      assign tail_data  = sh_data[READ_LATENCY-2];
    end
  endgenerate

  // Output stage: strobe every completed read, hold data otherwise
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= tail_valid;
      if (tail_valid) begin
        dout_q <= tail_data;
      end
    end
  end

  assign bus.doutb       = dout_q;
  assign bus.doutb_valid = valid_q;
  assign bus.init_busy   = (state_q == S_INIT);

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: directed bench for sdp_ram_pipe.
// u0: depth 16, latency 1, INIT A5 (clear, byte enables, collisions)
// u1: depth 16, latency 3 (back-to-back throughput)
// u2: depth 12, latency 4, INIT 3C (latency, out of range, reset mid-read)
module tb_sdp_ram_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int checks = 0;
  int errors = 0;

`ifdef SDP_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  sdp_ram_pipe_if #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
  sdp_ram_pipe_if #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) if1 ();
  sdp_ram_pipe_if #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) if2 ();

  sdp_ram_pipe #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16),
                 .READ_LATENCY(1), .INIT_DATA(64'hA5))
    u0 (.clka(clk), .rst(rst0), .bus(if0));
  sdp_ram_pipe #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16),
                 .READ_LATENCY(3), .INIT_DATA(64'h0))
    u1 (.clka(clk), .rst(rst1), .bus(if1));
  sdp_ram_pipe #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(12),
                 .READ_LATENCY(4), .INIT_DATA(64'h3C))
    u2 (.clka(clk), .rst(rst2), .bus(if2));

  typedef struct {
    logic [7:0]  wea;
    logic [3:0]  addra;
    logic [63:0] dina;
    logic        enb;
    logic [3:0]  addrb;
    logic        exp_valid;
    logic [63:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input int d);
    case (d)
      0: return if0.init_busy;
      1: return if1.init_busy;
      default: return if2.init_busy;
    endcase
  endfunction

  function automatic logic valid_of(input int d);
    case (d)
      0: return if0.doutb_valid;
      1: return if1.doutb_valid;
      default: return if2.doutb_valid;
    endcase
  endfunction

  // Count edges until init_busy falls (bounded); no valid may appear
  task automatic run_clear(input int d, input int depth);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      n++;
      if (valid_of(d)) seen = 1'b1;
      if (!busy_of(d)) break;
    end
    check($sformatf("u%0d_clear_len", d), 64'(n), 64'(depth));
    check($sformatf("u%0d_no_valid_in_init", d), {63'b0, seen}, 64'h0);
  endtask

  // Single read on u2 (latency 4): issue, then three more edges
  task automatic read2(input logic [3:0] a, input logic [63:0] exp, input string name);
    if2.addrb = a;
    if2.enb   = 1'b1;
    tick();
    if2.enb = 1'b0;
    tick(); tick(); tick();
    check({name, "_valid"}, {63'b0, if2.doutb_valid}, 64'h1);
    check({name, "_data"}, if2.doutb, exp);
  endtask

  initial begin
    vecs[0]  = '{8'hFF, 4'd3,  64'h1122334455667788, 1'b0, 4'd0,  1'b0, 64'hA5};
    vecs[1]  = '{8'h0F, 4'd3,  64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0,  1'b0, 64'hA5};
    vecs[2]  = '{8'h00, 4'd0,  64'h0,                1'b1, 4'd3,  1'b1, 64'h11223344FFFFFFFF};
    vecs[3]  = '{8'h80, 4'd7,  64'h0123456789ABCDEF, 1'b1, 4'd3,  1'b1, 64'h11223344FFFFFFFF};
    vecs[4]  = '{8'h00, 4'd0,  64'h0,                1'b1, 4'd7,  1'b1, 64'h01000000000000A5};
    vecs[5]  = '{8'h00, 4'd0,  64'h0,                1'b0, 4'd0,  1'b0, 64'h01000000000000A5};
    vecs[6]  = '{8'hFF, 4'd5,  64'h0,                1'b1, 4'd4,  1'b1, 64'hA5};
    vecs[7]  = '{8'h03, 4'd5,  64'hDEAD,             1'b1, 4'd5,  1'b1, BYP ? 64'hDEAD : 64'h0};
    vecs[8]  = '{8'h00, 4'd0,  64'h0,                1'b1, 4'd5,  1'b1, 64'hDEAD};
    vecs[9]  = '{8'h00, 4'd5,  64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd5,  1'b1, 64'hDEAD};
    vecs[10] = '{8'hFF, 4'd15, 64'hCAFE,             1'b1, 4'd15, 1'b1, BYP ? 64'hCAFE : 64'hA5};
    vecs[11] = '{8'h00, 4'd0,  64'h0,                1'b1, 4'd15, 1'b1, 64'hCAFE};

    if0.wea = '0; if0.addra = '0; if0.dina = '0; if0.enb = 1'b0; if0.addrb = '0;
    if1.wea = '0; if1.addra = '0; if1.dina = '0; if1.enb = 1'b0; if1.addrb = '0;
    if2.wea = '0; if2.addra = '0; if2.dina = '0; if2.enb = 1'b0; if2.addrb = '0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    tick(); tick();

    check("u0_rst_dout",  if0.doutb, 64'h0);
    check("u0_rst_valid", {63'b0, if0.doutb_valid}, 64'h0);
    check("u0_rst_busy",  {63'b0, if0.init_busy}, 64'h1);

    // u0 clear pass with requests held active; they must be ignored
    if0.wea = 8'hFF; if0.addra = 4'd0; if0.dina = 64'h1234; if0.enb = 1'b1; if0.addrb = 4'd0;
    rst0 = 1'b0;
    run_clear(0, 16);
    if0.wea = '0; if0.enb = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if0.addrb = 4'(i);
      if0.enb   = 1'b1;
      tick();
      check($sformatf("u0_clr_rd%0d_valid", i), {63'b0, if0.doutb_valid}, 64'h1);
      check($sformatf("u0_clr_rd%0d_data", i), if0.doutb, 64'hA5);
    end
    if0.enb = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if0.wea   = vecs[i].wea;
      if0.addra = vecs[i].addra;
      if0.dina  = vecs[i].dina;
      if0.enb   = vecs[i].enb;
      if0.addrb = vecs[i].addrb;
      tick();
      check($sformatf("vec%0d_valid", i), {63'b0, if0.doutb_valid}, {63'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_data", i), if0.doutb, vecs[i].exp_dout);
    end
    if0.wea = '0; if0.enb = 1'b0;

    // u1: fill 0..7 then eight back-to-back reads at latency 3
    rst1 = 1'b0;
    run_clear(1, 16);
    for (int i = 0; i < 8; i++) begin
      if1.wea   = 8'hFF;
      if1.addra = 4'(i);
      if1.dina  = 64'h1000 + 64'(i) * 64'h1111;
      tick();
    end
    if1.wea = '0;
    for (int c = 0; c < 12; c++) begin
      logic        ev;
      logic [63:0] ed;
      if1.enb   = (c < 8);
      if1.addrb = 4'(c);
      tick();
      ev = (c >= 2) && (c < 10);
      if (c < 2)       ed = 64'h0;
      else if (c < 10) ed = 64'h1000 + 64'(c - 2) * 64'h1111;
      else             ed = 64'h1000 + 64'd7 * 64'h1111;
      check($sformatf("u1_c%0d_valid", c), {63'b0, if1.doutb_valid}, {63'b0, ev});
      check($sformatf("u1_c%0d_data", c), if1.doutb, ed);
    end
    if1.enb = 1'b0;

    // u2: exact latency 4, then out-of-range and last-entry reads
    rst2 = 1'b0;
    run_clear(2, 12);
    if2.wea = 8'hFF; if2.addra = 4'd2; if2.dina = 64'h5555;
    tick();
    if2.wea = '0;
    if2.addrb = 4'd2;
    if2.enb   = 1'b1;
    tick();
    if2.enb = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      check($sformatf("u2_lat_t%0d_valid", t), {63'b0, if2.doutb_valid}, (t == 4) ? 64'h1 : 64'h0);
      if (t == 4) check("u2_lat_data", if2.doutb, 64'h5555);
      if (t < 5) tick();
    end

    if2.wea = 8'hFF; if2.addra = 4'd13; if2.dina = 64'h77;
    tick();
    if2.wea = '0;
    read2(4'd1,  64'h3C, "u2_rd1");
    read2(4'd13, 64'h0,  "u2_oor13");
    read2(4'd11, 64'h3C, "u2_rd11");

    // Reset two cycles after a read is launched
    if2.addrb = 4'd2;
    if2.enb   = 1'b1;
    tick();
    if2.enb = 1'b0;
    tick();
    #1;
    rst2 = 1'b1;
    #1;
    check("u2_midrst_valid", {63'b0, if2.doutb_valid}, 64'h0);
    check("u2_midrst_dout",  if2.doutb, 64'h0);
    check("u2_midrst_busy",  {63'b0, if2.init_busy}, 64'h1);
    tick(); tick();
    check("u2_midrst_novalid", {63'b0, if2.doutb_valid}, 64'h0);
    rst2 = 1'b0;
    run_clear(2, 12);
    read2(4'd2, 64'h3C, "u2_after_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdp_ram_pipe.md
# sdp_ram_pipe

Parametrised simple-dual-port, single-clock RAM for the FIFO and buffer datapaths. Adds four features to the basic SDP RAM:
- per-byte write enables;
- a configurable read-pipeline depth with a read-valid strobe;
- a hardware clear sequencer that rewrites every entry to `INIT_DATA` after reset;
- optional write-to-read forwarding on address collision.

It replaces the fixed-latency SDP RAM wherever the consumer needs a valid strobe or a deterministic post-reset memory state.

## Interface
Parameters:
- `DATA_WIDTH`, 64: word width; must be a multiple of `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8: bits per write-enable lane; `NB = DATA_WIDTH/BYTE_WIDTH`.
- `ADDR_WIDTH`, 9: address bus width.
- `RAM_DEPTH`, 512: number of entries, at most 2^`ADDR_WIDTH`.
- `READ_LATENCY`, 1: read pipeline depth, legal range 1..4.
- `INIT_DATA`, 0: value written to every entry by the clear sequencer.

Ports:
- `clka` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `wea` in `NB`: per-byte write enable; bit i writes `dina[i*BYTE_WIDTH +: BYTE_WIDTH]`.
- `addra` in `ADDR_WIDTH`: write address.
- `dina` in `DATA_WIDTH`: write data.
- `enb` in 1: read request.
- `addrb` in `ADDR_WIDTH`: read address.
- `doutb` out `DATA_WIDTH`: read data; holds its last value between reads.
- `doutb_valid` out 1: one-cycle strobe per completed read.
- `init_busy` out 1: clear sequencer active; all requests are ignored while high.

## Operation
- FSM has two states, `S_INIT` and `S_RUN`.
- `rst` forces `S_INIT` with clear counter 0.
- `S_INIT`:
  - Each cycle, writes `INIT_DATA` to the entry at the counter, then increments the counter.
  - After writing entry `RAM_DEPTH-1`, moves to `S_RUN`.
  - `wea` and `enb` are ignored; no `doutb_valid` is produced.
- `S_RUN`:
  - Any `wea` bit set writes the enabled bytes of `dina` to `addra`; the other bytes keep their contents.
  - `enb` launches a read of `addrb` into the pipeline.
  - A read of the same address in the same cycle as a write returns the pre-write data, unless forwarding is compiled in (see Configuration).
- Out-of-range addresses (`addr >= RAM_DEPTH`):
  - Writes are dropped.
  - Reads complete normally with `doutb = 0`.
- The read pipeline is a `READ_LATENCY`-deep chain of data and valid registers.
  - `doutb` loads only when the last valid stage is 1; otherwise it holds.
  - A new read may be issued every cycle, giving full throughput with no stalls.
- Reset mid-operation:
  - All in-flight reads are discarded and `doutb_valid` drops immediately.
  - Memory contents are not asynchronously cleared; they are rewritten by the restarted `S_INIT` pass.

## Timing
- Reset values: `doutb = 0`, `doutb_valid = 0`, `init_busy = 1`.
- Clear duration: `init_busy` stays high for exactly `RAM_DEPTH` rising edges after `rst` deasserts. The first accepted request is on the edge after `init_busy` falls.
- Read latency: with `enb` sampled on edge k, `doutb` and `doutb_valid` update on edge k+`READ_LATENCY`-1.
  - `READ_LATENCY = 1` gives the same behaviour as the basic SDP RAM.
- Write latency: a write on edge k is visible to a read sampled on edge k+1.
- `doutb_valid` is high for one cycle per read. Back-to-back reads give a contiguous run of valid cycles.

## Configuration
- Macro `SDP_RAM_BYPASS_EN` selects collision behaviour.
- Defined:
  - When `enb` and at least one `wea` bit are set in the same cycle with `addra == addrb`, the read returns the byte-wise merge: new `dina` bytes where `wea` is set, stored bytes elsewhere.
  - Forwarding adds no latency.
- Undefined:
  - The same collision returns the old stored word (read-first).
  - No forwarding logic is synthesised.

## Test plan
- Reset and clear:
  - Stimulus: `RAM_DEPTH = 16`, `INIT_DATA = 64'hA5`; release `rst`, then read addresses 0..15.
  - Required: `init_busy` high for 16 cycles; all reads return `64'hA5`.
- Byte enables:
  - Stimulus: write `64'h1122334455667788` with `wea = 8'hFF` to address 3, then `64'hFFFF…FF` with `wea = 8'h0F` to address 3; read address 3.
  - Required: `doutb = 64'h11223344FFFFFFFF`.
- Latency and throughput:
  - Stimulus: `READ_LATENCY = 3`; reads of addresses 0..7 on consecutive edges, starting at edge k.
  - Required: `doutb_valid` high for 8 consecutive cycles starting at edge k+2, with data in address order.
- Collision:
  - Stimulus: address 5 holds `64'h0`; in one cycle, write `64'hDEAD` with `wea = 8'h03` and read address 5.
  - Required: `doutb = 64'h0` without `SDP_RAM_BYPASS_EN`; `64'hDEAD` with it.
- Reset mid-read:
  - Stimulus: `READ_LATENCY = 4`; assert `rst` two cycles after `enb`.
  - Required: no `doutb_valid` pulse; `doutb = 0`; a full clear pass follows.
- Out of range:
  - Stimulus: `RAM_DEPTH = 12`, `ADDR_WIDTH = 4`; write `64'h77` to address 13, then read address 13.
  - Required: write dropped; `doutb = 0`; `doutb_valid` pulses.
